// File: rtl/riscv_core_dcache_nway_controller.sv
// N-way set-associative, write-through, write-allocate D-cache controller for the RV64IMAC LSU/AMO path.
// Optional macro DCACHE_RES_TIMEOUT_EN adds a lifetime counter that expires LR reservations.
module riscv_core_dcache_nway_controller #(
  parameter int NUM_WAYS     = 2,
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 5,
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int RES_TIMEOUT  = 255,
  localparam int WAY_W       = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int STRB_W      = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic                  i_lr,
  input  logic                  i_sc,
  input  logic                  i_amo,
  input  logic [1:0]            i_size,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0] i_amo_result,
  input  logic                  i_flush,
  output logic                  o_flush_done,
  output logic                  o_stall,
  output logic                  o_load_fault,
  output logic                  o_store_fault,
  output logic                  o_amo_fault,
  output logic [DATA_WIDTH-1:0] o_sc_result,
  output logic                  o_rd_en,
  output logic                  o_wr_en,
  output logic                  o_block_replace,
  output logic                  o_amo_wr,
  output logic [WAY_W-1:0]      o_way,
  output logic                  o_mem_read_req,
  output logic [ADDR_WIDTH-1:0] o_mem_read_address,
  input  logic                  i_mem_read_done,
  output logic                  o_mem_write_valid,
  output logic [ADDR_WIDTH-1:0] o_mem_write_address,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  output logic [STRB_W-1:0]     o_mem_write_strobe,
  input  logic                  i_mem_write_done
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int BSEL_W    = $clog2(STRB_W);
  localparam int GRAN_W    = ADDR_WIDTH - 3;
  localparam int LINE_W    = TAG_WIDTH + INDEX_WIDTH;
  localparam int FCNT_W    = (INDEX_WIDTH > 8) ? INDEX_WIDTH : 8;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_MEM_REQ   = 3'd1;
  localparam logic [2:0] S_REFILL    = 3'd2;
  localparam logic [2:0] S_MEM_WRITE = 3'd3;
  localparam logic [2:0] S_AMO_OP    = 3'd4;
  localparam logic [2:0] S_FLUSH     = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [TAG_WIDTH-1:0]  tag_q [NUM_WAYS][SETS];
  logic [NUM_WAYS-1:0]   valid_q [SETS];
  logic [WAY_W-1:0]      rr_q [SETS];
  logic [FCNT_W-1:0]     flush_cnt_q;
  logic                  cur_amo_q;
  logic [WAY_W-1:0]      cur_way_q;
  logic                  res_valid_q;
  logic [GRAN_W-1:0]     res_gran_q;

  logic [INDEX_WIDTH-1:0] req_idx;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic                   hit, victim_invalid, evict_hits_res;
  logic [WAY_W-1:0]       hit_way, victim_way;
  logic                   sel_read, sel_lr, sel_write, sel_sc, sel_amo, any_req;
  logic                   misaligned, fault, res_match, res_expire;
  logic [STRB_W-1:0]      size_mask;
  logic                   res_set, res_clr, refill_we, rr_adv, flush_clr, flush_end, latch_op;

  assign req_idx = i_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_tag = i_addr[OFFSET_WIDTH + INDEX_WIDTH +: TAG_WIDTH];

  // Descending scans so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    victim_invalid = 1'b0;
    victim_way     = rr_q[req_idx];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        victim_invalid = 1'b1;
        victim_way     = WAY_W'(w);
      end
    end
  end

  assign evict_hits_res = !victim_invalid && res_valid_q &&
                          (res_gran_q[GRAN_W-1 -: LINE_W] == {tag_q[victim_way][req_idx], req_idx});

  assign sel_read  = i_read;
  assign sel_lr    = !i_read && i_lr;
  assign sel_write = !i_read && !i_lr && i_write;
  assign sel_sc    = !i_read && !i_lr && !i_write && i_sc;
  assign sel_amo   = !i_read && !i_lr && !i_write && !i_sc && i_amo;
  assign any_req   = i_read | i_lr | i_write | i_sc | i_amo;

  always_comb begin
    case (i_size)
      2'b01:   misaligned = i_addr[0];
      2'b10:   misaligned = |i_addr[1:0];
      2'b11:   misaligned = |i_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign fault     = misaligned || ((sel_lr || sel_sc || sel_amo) && !i_size[1]);
  assign res_match = res_valid_q && (res_gran_q == i_addr[ADDR_WIDTH-1:3]);

  always_comb begin
    case (i_size)
      2'b00:   size_mask = STRB_W'(8'h01);
      2'b01:   size_mask = STRB_W'(8'h03);
      2'b10:   size_mask = STRB_W'(8'h0F);
      default: size_mask = STRB_W'(8'hFF);
    endcase
  end

  assign o_mem_read_address  = {i_addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
  assign o_mem_write_address = i_addr;
  assign o_mem_write_strobe  = size_mask << i_addr[BSEL_W-1:0];
  assign o_mem_write_data    = ((state_q != S_IDLE) && cur_amo_q) ? i_amo_result : i_wdata;

  // Requests are only decoded in IDLE; held inputs let later states reuse i_addr/i_wdata.
  always_comb begin
    state_d         = state_q;
    o_stall         = 1'b0;
    o_load_fault    = 1'b0;
    o_store_fault   = 1'b0;
    o_amo_fault     = 1'b0;
    o_sc_result     = '0;
    o_rd_en         = 1'b0;
    o_wr_en         = 1'b0;
    o_block_replace = 1'b0;
    o_amo_wr        = 1'b0;
    o_way           = cur_way_q;
    o_mem_read_req  = 1'b0;
    o_mem_write_valid = 1'b0;
    o_flush_done    = 1'b0;
    res_set         = 1'b0;
    res_clr         = 1'b0;
    refill_we       = 1'b0;
    rr_adv          = 1'b0;
    flush_clr       = 1'b0;
    flush_end       = 1'b0;
    latch_op        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_rst_n && any_req) begin
          if (fault) begin
            o_load_fault  = sel_read | sel_lr;
            o_store_fault = sel_write | sel_sc;
            o_amo_fault   = sel_amo;
          end else if (!hit) begin
            o_mem_read_req = 1'b1;
            o_stall        = 1'b1;
            state_d        = S_MEM_REQ;
          end else begin
            o_way = hit_way;
            if (sel_read || sel_lr) begin
              o_rd_en = 1'b1;
              res_set = sel_lr;
            end else if (sel_write || (sel_sc && res_match)) begin
              o_wr_en           = 1'b1;
              o_mem_write_valid = 1'b1;
              o_stall           = 1'b1;
              latch_op          = 1'b1;
              state_d           = S_MEM_WRITE;
            end else if (sel_amo) begin
              o_rd_en  = 1'b1;
              o_stall  = 1'b1;
              latch_op = 1'b1;
              state_d  = S_AMO_OP;
            end else begin
              o_sc_result = DATA_WIDTH'(1);
            end
            if (sel_sc) res_clr = 1'b1;
          end
        end else if (i_rst_n && i_flush) begin
          state_d = S_FLUSH;
        end
      end
      S_MEM_REQ: begin
        o_stall = 1'b1;
        if (i_mem_read_done) state_d = S_REFILL;
        else                 o_mem_read_req = 1'b1;
      end
      S_REFILL: begin
        o_stall         = 1'b1;
        o_wr_en         = 1'b1;
        o_block_replace = 1'b1;
        o_way           = victim_way;
        refill_we       = 1'b1;
        rr_adv          = !victim_invalid;
        res_clr         = evict_hits_res;
        state_d         = S_IDLE;
      end
      S_AMO_OP: begin
        o_rd_en = 1'b1;
        o_stall = 1'b1;
        state_d = S_MEM_WRITE;
      end
      S_MEM_WRITE: begin
        if (i_mem_write_done) begin
          o_wr_en  = cur_amo_q;
          o_amo_wr = cur_amo_q;
          state_d  = S_IDLE;
        end else begin
          o_mem_write_valid = 1'b1;
          o_stall           = 1'b1;
        end
      end
      S_FLUSH: begin
        o_stall   = 1'b1;
        flush_clr = 1'b1;
        if (flush_cnt_q == FCNT_W'(SETS - 1)) begin
          o_flush_done = 1'b1;
          flush_end    = 1'b1;
          res_clr      = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= '0;
      cur_amo_q   <= 1'b0;
      cur_way_q   <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= (state_q == S_FLUSH) ? flush_cnt_q + 1'b1 : '0;
      if (latch_op) begin
        cur_amo_q <= sel_amo;
        cur_way_q <= hit_way;
      end
    end
  end

  // Round-robin pointer only moves when a valid line is actually displaced.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (flush_clr) begin
      valid_q[flush_cnt_q[INDEX_WIDTH-1:0]] <= '0;
      if (flush_end) begin
        for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      end
    end else if (refill_we) begin
      valid_q[req_idx][victim_way] <= 1'b1;
      if (rr_adv) begin
        rr_q[req_idx] <= (rr_q[req_idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[req_idx] + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (refill_we) tag_q[victim_way][req_idx] <= req_tag;
  end

`ifdef DCACHE_RES_TIMEOUT_EN
  localparam int RCNT_W = ($clog2(RES_TIMEOUT + 1) > 8) ? $clog2(RES_TIMEOUT + 1) : 8;
  logic [RCNT_W-1:0] res_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)             res_cnt_q <= '0;
    else if (res_set)         res_cnt_q <= RCNT_W'(RES_TIMEOUT);
    else if (res_cnt_q != '0) res_cnt_q <= res_cnt_q - 1'b1;
  end

  assign res_expire = res_valid_q && (res_cnt_q == '0);
`else
  assign res_expire = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_valid_q <= 1'b0;
      res_gran_q  <= '0;
    end else if (res_clr) begin
      res_valid_q <= 1'b0;
    end else if (res_set) begin
      res_valid_q <= 1'b1;
      res_gran_q  <= i_addr[ADDR_WIDTH-1:3];
    end else if (res_expire) begin
      res_valid_q <= 1'b0;
    end
  end

endmodule
